uio_tx_link_arb: RTL and testbench

//  Round-robin arbiter sharing one 64-bit Aurora AXI-Stream TX link among NUM_REQ

---
 rtl/uio_tx_link_arb.sv | 184 ++++++++++++++++++
 tb/tb_uio_tx_link_arb.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_tx_link_arb.sv
// uio_tx_link_arb
// Round-robin arbiter that shares one 64-bit Aurora AXI-Stream TX link among
// NUM_REQ user-IO request ports. Each port owns a small word FIFO; a granted
// word is sent as a one-beat header followed by UIO_PORTS_WIDTH/64 data beats,
// least-significant beat first.
module uio_tx_link_arb #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned UIO_PORTS_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned AFULL_LVL       = 6
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               i_stat_chan_up,
  input  logic [NUM_REQ-1:0]                 uio_rq_vld,
  input  logic [NUM_REQ*UIO_PORTS_WIDTH-1:0] uio_rq_data,
  output logic [NUM_REQ-1:0]                 uio_rq_afull,
  output logic [63:0]                        o_s_axi_tx_tdata,
  output logic [7:0]                         o_s_axi_tx_tkeep,
  output logic                               o_s_axi_tx_tlast,
  output logic                               o_s_axi_tx_tvalid,
  input  logic                               i_s_axi_tx_tready,
  output logic [NUM_REQ-1:0]                 o_ovf,
  output logic                               o_busy
);

  localparam int unsigned NB = UIO_PORTS_WIDTH / 64;
  localparam int unsigned BW = $clog2(NB) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t state, state_nxt;

  // rr_last doubles as the current grant: it is latched on the grant decision
  // and holds until the next one, so one register serves both roles.
  logic [GW-1:0] rr_last, rr_last_nxt;
  logic [BW-1:0] beat, beat_nxt;

  logic [UIO_PORTS_WIDTH-1:0] mem [NUM_REQ][FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr [NUM_REQ];
  logic [AW-1:0]              rd_ptr [NUM_REQ];
  logic [CW-1:0]              count [NUM_REQ];
  logic [CW-1:0]              cnt_nxt [NUM_REQ];

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] ovf_set;

  logic                       found;
  logic [GW-1:0]              pick;
  int unsigned                rr_idx;
  logic [UIO_PORTS_WIDTH-1:0] head_word;

  // Per-port FIFO status, push/drop decision and next occupancy.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      full[i]     = (count[i] == CW'(FIFO_DEPTH));
      nonempty[i] = (count[i] != '0);
      push[i]     = uio_rq_vld[i] && !full[i];
      ovf_set[i]  = uio_rq_vld[i] && full[i];
      pop[i]      = (state == DATA) && i_s_axi_tx_tready &&
                    (beat == LAST_BEAT) && (rr_last == GW'(i));
      case ({push[i], pop[i]})
        2'b10:   cnt_nxt[i] = count[i] + 1'b1;
        2'b01:   cnt_nxt[i] = count[i] - 1'b1;
        default: cnt_nxt[i] = count[i];
      endcase
    end
  end

  // FIFO pointers, occupancy, registered almost-full and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      uio_rq_afull <= '0;
      o_ovf        <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i]        <= cnt_nxt[i];
        uio_rq_afull[i] <= (cnt_nxt[i] >= CW'(AFULL_LVL));
        if (ovf_set[i]) o_ovf[i] <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= uio_rq_data[i*UIO_PORTS_WIDTH +: UIO_PORTS_WIDTH];
      end
    end
  end

  // Round-robin search: first non-empty port after rr_last, with wrap.
  always_comb begin
    found  = 1'b0;
    pick   = rr_last;
    rr_idx = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = 32'(rr_last) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && nonempty[GW'(rr_idx)]) begin
        found = 1'b1;
        pick  = GW'(rr_idx);
      end
    end
  end

  // FSM state, grant and beat registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr_last <= GW'(NUM_REQ - 1);
      beat    <= '0;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
      beat    <= beat_nxt;
    end
  end

  // FSM next state and AXI-Stream outputs; outputs follow registered state
  // only, so they stay stable while tvalid waits for tready.
  always_comb begin
    state_nxt         = state;
    rr_last_nxt       = rr_last;
    beat_nxt          = beat;
    o_s_axi_tx_tvalid = 1'b0;
    o_s_axi_tx_tkeep  = '0;
    o_s_axi_tx_tlast  = 1'b0;
    o_s_axi_tx_tdata  = '0;
    o_busy            = (state != IDLE);
    head_word         = mem[rr_last][rd_ptr[rr_last]];
    case (state)
      IDLE: begin
        if (i_stat_chan_up && found) begin
          rr_last_nxt = pick;
          state_nxt   = HDR;
        end
      end
      HDR: begin
        o_s_axi_tx_tvalid = 1'b1;
        o_s_axi_tx_tkeep  = '1;
        o_s_axi_tx_tdata  = {8'hA5, 48'h0, 8'(rr_last)};
        if (i_s_axi_tx_tready) begin
          state_nxt = DATA;
          beat_nxt  = '0;
        end
      end
      DATA: begin
        o_s_axi_tx_tvalid = 1'b1;
        o_s_axi_tx_tkeep  = '1;
        o_s_axi_tx_tdata  = head_word[64*beat +: 64];
        o_s_axi_tx_tlast  = (beat == LAST_BEAT);
        if (i_s_axi_tx_tready) begin
          if (beat == LAST_BEAT) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uio_tx_link_arb.sv
// Testbench for uio_tx_link_arb: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of ports and packets.
module tb_uio_tx_link_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 128;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFULL = 6;
  localparam int unsigned NB    = W / 64;
  localparam int unsigned VW    = 75 + 2 * NREQ;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              chan_up = 1'b0;
  logic              tready = 1'b0;
  logic [NREQ-1:0]   vld = '0;
  logic [NREQ*W-1:0] data = '0;
  logic [NREQ-1:0]   afull;
  logic [63:0]       tdata;
  logic [7:0]        tkeep;
  logic              tlast;
  logic              tvalid;
  logic [NREQ-1:0]   ovf;
  logic              busy;

  always #5 clk = ~clk;

  uio_tx_link_arb #(
    .NUM_REQ(NREQ),
    .UIO_PORTS_WIDTH(W),
    .FIFO_DEPTH(DEPTH),
    .AFULL_LVL(AFULL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_stat_chan_up(chan_up),
    .uio_rq_vld(vld),
    .uio_rq_data(data),
    .uio_rq_afull(afull),
    .o_s_axi_tx_tdata(tdata),
    .o_s_axi_tx_tkeep(tkeep),
    .o_s_axi_tx_tlast(tlast),
    .o_s_axi_tx_tvalid(tvalid),
    .i_s_axi_tx_tready(tready),
    .o_ovf(ovf),
    .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-port word queues, the beat list of the packet in
  // flight, the round-robin pointer and the sticky overflow flags.
  logic [W-1:0]    q[NREQ][$];
  logic [63:0]     beats[$];
  bit              in_flight;
  int unsigned     rr;
  logic [NREQ-1:0] m_ovf;

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < NREQ; i++) q[i].delete();
    beats.delete();
    in_flight = 1'b0;
    rr        = NREQ - 1;
    m_ovf     = '0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NREQ-1:0] af;
    logic [63:0]     hb;
    hb = '0;
    if (in_flight && beats.size() > 0) hb = beats[0];
    for (int unsigned i = 0; i < NREQ; i++) af[i] = (q[i].size() >= AFULL);
    return {in_flight, (in_flight && beats.size() == 1), (in_flight ? 8'hFF : 8'h00),
            hb, in_flight, af, m_ovf};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {tvalid, tlast, tkeep, tdata, busy, afull, ovf};
  endfunction

  function automatic bit model_hdr();
    return in_flight && (beats.size() == NB + 1);
  endfunction

  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic tick();
    bit           was_full[NREQ];
    bit           found;
    int unsigned  p;
    logic [W-1:0] w;
    for (int unsigned i = 0; i < NREQ; i++) was_full[i] = (q[i].size() == DEPTH);
    if (in_flight) begin
      if (tready) begin
        void'(beats.pop_front());
        if (beats.size() == 0) begin
          void'(q[rr].pop_front());
          in_flight = 1'b0;
        end
      end
    end else if (chan_up) begin
      found = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
        p = (rr + k) % NREQ;
        if (!found && q[p].size() > 0) begin
          found = 1'b1;
          rr    = p;
        end
      end
      if (found) begin
        w = q[rr][0];
        beats.push_back({8'hA5, 48'h0, 8'(rr)});
        for (int unsigned b = 0; b < NB; b++) beats.push_back(w[b*64 +: 64]);
        in_flight = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (vld[i]) begin
        if (was_full[i]) m_ovf[i] = 1'b1;
        else q[i].push_back(data[i*W +: W]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vld     = '0;
    data    = '0;
    tready  = 1'b0;
    chan_up = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tvalid, tlast, tkeep, tdata, busy, afull, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {tvalid, tlast, tkeep, tdata, busy, afull, ovf});
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    logic [63:0] exp_b[3];
    logic [63:0] got[$];
    int          cyc[$];
    bit          tl[$];
    exp_b[0] = 64'hA500000000000000;
    exp_b[1] = 64'h2222222222222222;
    exp_b[2] = 64'h1111111111111111;
    do_reset();
    chan_up = 1'b1;
    tready  = 1'b1;
    data[0 +: W] = 128'h1111111111111111_2222222222222222;
    vld = 4'b0001;
    tick();
    vld = '0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_cycle%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      if (tvalid && tready) begin
        got.push_back(tdata);
        cyc.push_back(c);
        tl.push_back(tlast);
      end
      tick();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL single_beat_count got %0d required 3", got.size());
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== exp_b[k] || tl[k] !== (k == 2)) begin
          errors++;
          $display("FAIL single_beat%0d got %h/%b required %h/%b", k, got[k], tl[k], exp_b[k], k == 2);
        end
      end
      checks++;
      if (cyc[2] - cyc[0] != 2) begin
        errors++;
        $display("FAIL single_consecutive got span %0d required 2", cyc[2] - cyc[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after got %b required 0", busy);
    end
  endtask

  task automatic test_all_ports();
    int ids[$];
    int hc[$];
    do_reset();
    chan_up = 1'b1;
    tready  = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) data[i*W +: W] = rand_word();
    vld = '1;
    tick();
    vld = '0;
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL allports_cycle%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      if (tvalid && tready && model_hdr()) begin
        ids.push_back(int'(tdata[7:0]));
        hc.push_back(c);
      end
      tick();
    end
    checks++;
    if (ids.size() != NREQ) begin
      errors++;
      $display("FAIL allports_packets got %0d required %0d", ids.size(), NREQ);
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        checks++;
        if (ids[k] != int'(k)) begin
          errors++;
          $display("FAIL allports_order%0d got %0d required %0d", k, ids[k], k);
        end
        if (k > 0) begin
          checks++;
          if (hc[k] - hc[k-1] != NB + 2) begin
            errors++;
            $display("FAIL allports_spacing%0d got %0d required %0d", k, hc[k] - hc[k-1], NB + 2);
          end
        end
      end
    end
  endtask

  task automatic test_fairness();
    int exp_ids[6];
    int ids[$];
    exp_ids = '{1, 3, 1, 3, 1, 3};
    do_reset();
    tready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      data[1*W +: W] = rand_word();
      data[3*W +: W] = rand_word();
      vld = 4'b1010;
      tick();
    end
    vld = '0;
    chan_up = 1'b1;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fair_cycle%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      if (tvalid && tready && model_hdr()) ids.push_back(int'(tdata[7:0]));
      tick();
    end
    checks++;
    if (ids.size() != 6) begin
      errors++;
      $display("FAIL fair_packets got %0d required 6", ids.size());
    end else begin
      for (int unsigned k = 0; k < 6; k++) begin
        checks++;
        if (ids[k] != exp_ids[k]) begin
          errors++;
          $display("FAIL fair_grant%0d got %0d required %0d", k, ids[k], exp_ids[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] hold;
    bit          reached;
    do_reset();
    tready = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      data[2*W +: W] = rand_word();
      vld = 4'b0100;
      tick();
    end
    vld = '0;
    chan_up = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      if (in_flight && beats.size() == NB) reached = 1'b1;
      else tick();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL bp_reach_data0 got timeout required data beat 0");
    end
    tready = 1'b0;
    hold   = tdata;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== hold || afull[2] !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%b d=%h af=%b required v=1 d=%h af=1", c, tvalid, tdata, afull[2], hold);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_stall_model%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    tready = 1'b1;
    for (int c = 0; c < 10 && in_flight; c++) tick();
    checks++;
    if (afull[2] !== 1'b0 || in_flight) begin
      errors++;
      $display("FAIL bp_pop_after_last got af=%b required af=0", afull[2]);
    end
    for (int c = 0; c < 30; c++) begin
      tready = ($urandom_range(0, 3) != 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_drain%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_chan_down();
    int npk;
    do_reset();
    tready = 1'b1;
    for (int unsigned k = 1; k <= 9; k++) begin
      data[2*W +: W] = rand_word();
      vld = 4'b0100;
      tick();
      vld = '0;
      checks++;
      if (afull[2] !== (k >= AFULL) || ovf[2] !== (k == 9) || tvalid !== 1'b0) begin
        errors++;
        $display("FAIL chandown_write%0d got af=%b ovf=%b v=%b required af=%b ovf=%b v=0",
                 k, afull[2], ovf[2], tvalid, k >= AFULL, k == 9);
      end
    end
    chan_up = 1'b1;
    npk = 0;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL chandown_cycle%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      if (tvalid && tready && model_hdr()) npk++;
      tick();
    end
    checks++;
    if (npk != 8 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL chandown_packets got %0d v=%b required 8 v=0", npk, tvalid);
    end
  endtask

  task automatic test_chan_drop();
    bit reached;
    int ndata;
    int nlast;
    int nhdr;
    do_reset();
    chan_up = 1'b1;
    data[1*W +: W] = rand_word();
    vld = 4'b0010;
    tick();
    vld = '0;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      if (model_hdr()) reached = 1'b1;
      else tick();
    end
    checks++;
    if (!reached || tvalid !== 1'b1) begin
      errors++;
      $display("FAIL drop_reach_hdr got v=%b required header presented", tvalid);
    end
    chan_up = 1'b0;
    data[0 +: W] = rand_word();
    vld = 4'b0001;
    tick();
    vld    = '0;
    tready = 1'b1;
    ndata = 0;
    nlast = 0;
    nhdr  = 0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_cycle%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      if (tvalid && tready) begin
        if (model_hdr()) nhdr++;
        else ndata++;
        if (tlast) nlast++;
      end
      tick();
    end
    checks++;
    if (ndata != NB + 0 || nlast != 1 || nhdr != 1) begin
      errors++;
      $display("FAIL drop_complete got data=%0d last=%0d hdr=%0d required data=%0d last=1 hdr=1",
               ndata, nlast, nhdr, NB);
    end
    chan_up = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_resume%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      chan_up = ($urandom_range(0, 9) != 0);
      tready  = ($urandom_range(0, 9) < 7);
      for (int unsigned i = 0; i < NREQ; i++) begin
        vld[i] = ($urandom_range(0, 9) < 3);
        data[i*W +: W] = rand_word();
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    vld = '0;
  endtask

  task automatic test_reset_mid();
    bit reached;
    do_reset();
    tready = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      data[3*W +: W] = rand_word();
      vld = 4'b1000;
      tick();
    end
    vld = '0;
    chan_up = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      if (in_flight && beats.size() == NB) reached = 1'b1;
      else tick();
    end
    checks++;
    if (!reached || tvalid !== 1'b1 || afull[3] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup got v=%b af=%b required v=1 af=1", tvalid, afull[3]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || afull !== '0 || tkeep !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async got v=%b busy=%b af=%b keep=%h required all 0", tvalid, busy, afull, tkeep);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs_vec() !== exp_vec() || tvalid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_empty%0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ports();
    test_fairness();
    test_backpressure();
    test_chan_down();
    test_chan_drop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
